// File: rtl/tpu_regbank.sv
// tpu_regbank: TPU control/status register bank with slot channels, interval timer and sticky interrupt.
// Define TPU_SHADOW_EN to make TMR_HI a shadow byte committed atomically with TMR_LO.
module tpu_regbank #(
  parameter logic [7:0] BASE_ADDR = 8'h20,
  parameter int         N_CH      = 2,
  parameter int         TMR_W     = 16
) (
  input  logic                SYS_CLK,
  input  logic                SYS_RST,
  input  logic                we_rf,
  input  logic                re_rf,
  input  logic [7:0]          addr_rf,
  input  logic [7:0]          data_rf,
  output logic                ready_rf,
  output logic [7:0]          rdata_rf,
  output logic                rvalid_rf,
  output logic                RSTTPU,
  output logic                TXSLOT_EN,
  output logic                RXSLOT_EN,
  output logic                TIMERINTMSK,
  output logic                INTFLAG,
  output logic                TIMER_IRQ,
  output logic [8*N_CH-1:0]   TX_SLOT,
  output logic [8*N_CH-1:0]   RX_SLOT,
  output logic [TMR_W-1:0]    TIMER_INT_VALUE
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_COUNT = 2'd2;
  logic [4:0]        ctrl_q, ctrl_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d, cnt_q, cnt_d;
  logic [1:0]        state_q, state_d;
  logic              flag_q, flag_d, irq_q;
  logic [8*N_CH-1:0] tx_q, tx_d, rx_q, rx_d;
  logic [7:0]        rdata_q, rdata_d, slot_rd, tmr_hi_rd, off;
  logic              rvalid_q, acc_w, acc_r, wr_ctrl, run_ok, expire;
  assign ready_rf = ~SYS_RST;
  assign off      = addr_rf - BASE_ADDR;
  assign acc_w    = we_rf & ready_rf;
  assign acc_r    = re_rf & ready_rf & ~we_rf;
  assign wr_ctrl  = acc_w && off == 8'd0;
`ifdef TPU_SHADOW_EN
  logic [7:0] shadow_q, shadow_d;
  assign shadow_d  = (acc_w && off == 8'd1) ? data_rf : shadow_q;
  assign tmr_d     = (acc_w && off == 8'd2) ? {shadow_q, data_rf} : tmr_q;
  assign tmr_hi_rd = shadow_q;
  always_ff @(posedge SYS_CLK)
    shadow_q <= SYS_RST ? 8'h00 : shadow_d;
`else
  assign tmr_d     = (acc_w && off == 8'd1) ? {data_rf, tmr_q[7:0]} :
                     (acc_w && off == 8'd2) ? {tmr_q[TMR_W-1:8], data_rf} : tmr_q;
  assign tmr_hi_rd = tmr_q[TMR_W-1:8];
`endif
  // ctrl_q packs {TIMER_RUN, MSK, RXEN, TXEN, RSTTPU}; the flag lives in flag_q
  assign ctrl_d = wr_ctrl ? {data_rf[5], data_rf[3:0]} : ctrl_q;
  always_comb begin
    tx_d    = tx_q;
    rx_d    = rx_q;
    slot_rd = 8'h00;
    for (int i = 0; i < N_CH; i++) begin
      if (acc_w && off == 8'(5 + 2*i)) tx_d[8*i +: 8] = data_rf;
      if (acc_w && off == 8'(6 + 2*i)) rx_d[8*i +: 8] = data_rf;
      if (off == 8'(5 + 2*i)) slot_rd = tx_q[8*i +: 8];
      if (off == 8'(6 + 2*i)) slot_rd = rx_q[8*i +: 8];
    end
  end
  assign run_ok = ctrl_q[4] & ~ctrl_q[0] & |tmr_q;
  always_comb begin
    state_d = !run_ok ? S_IDLE : (state_q == S_IDLE) ? S_LOAD : S_COUNT;
    expire  = run_ok && state_q == S_COUNT && cnt_q == TMR_W'(1);
    cnt_d   = (!run_ok || state_q == S_IDLE) ? '0 :
              (state_q == S_LOAD || expire) ? tmr_q : cnt_q - TMR_W'(1);
    // expiry beats a same-cycle W1C clear; RSTTPU overrides both
    flag_d  = ctrl_q[0] ? 1'b0 : expire | (flag_q & ~(wr_ctrl & data_rf[4]));
    rdata_d = !acc_r ? rdata_q :
              off == 8'd0 ? {2'b00, ctrl_q[4], flag_q, ctrl_q[3:0]} :
              off == 8'd1 ? tmr_hi_rd :
              off == 8'd2 ? tmr_q[7:0] :
              off == 8'd3 ? cnt_q[TMR_W-1:8] :
              off == 8'd4 ? cnt_q[7:0] : slot_rd;
  end
  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      ctrl_q   <= '0;
      tmr_q    <= '0;
      cnt_q    <= '0;
      state_q  <= S_IDLE;
      flag_q   <= 1'b0;
      irq_q    <= 1'b0;
      tx_q     <= '0;
      rx_q     <= '0;
      rdata_q  <= 8'h00;
      rvalid_q <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      tmr_q    <= tmr_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      flag_q   <= flag_d;
      irq_q    <= flag_q & ctrl_q[3];
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      rdata_q  <= rdata_d;
      rvalid_q <= acc_r;
    end
  end
  assign rdata_rf        = rdata_q;
  assign rvalid_rf       = rvalid_q;
  assign RSTTPU          = ctrl_q[0];
  assign TXSLOT_EN       = ctrl_q[1];
  assign RXSLOT_EN       = ctrl_q[2];
  assign TIMERINTMSK     = ctrl_q[3];
  assign INTFLAG         = flag_q;
  assign TIMER_IRQ       = irq_q;
  assign TX_SLOT         = tx_q;
  assign RX_SLOT         = rx_q;
  assign TIMER_INT_VALUE = tmr_q;
endmodule

// File: tb/tb_tpu_regbank.sv
// tb_tpu_regbank: directed bench for tpu_regbank; reads are scored by a queue-driven monitor.
module tb_tpu_regbank;
  logic        clk, rst, we, re;
  logic [7:0]  addr, data, rdata;
  logic        ready, rvalid, rsttpu, txen, rxen, msk, flag, irq;
  logic [15:0] tx_slot, rx_slot, tmr_val;
  typedef struct { logic [7:0] d; string n; } exp_t;
  exp_t exp_q[$];
  int total = 0;
  int bad = 0;

  tpu_regbank dut (
    .SYS_CLK(clk), .SYS_RST(rst), .we_rf(we), .re_rf(re), .addr_rf(addr), .data_rf(data),
    .ready_rf(ready), .rdata_rf(rdata), .rvalid_rf(rvalid), .RSTTPU(rsttpu), .TXSLOT_EN(txen),
    .RXSLOT_EN(rxen), .TIMERINTMSK(msk), .INTFLAG(flag), .TIMER_IRQ(irq), .TX_SLOT(tx_slot),
    .RX_SLOT(rx_slot), .TIMER_INT_VALUE(tmr_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rvalid got=1 want=0 rdata=%h", rdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk(e.n, {24'h0, rdata}, {24'h0, e.d});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    we = 1'b1; addr = a; data = d;
    step();
    we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] d, input string n);
    exp_t e;
    e.d = d; e.n = n;
    exp_q.push_back(e);
    re = 1'b1; addr = a;
    step();
    re = 1'b0;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; re = 1'b0; addr = 8'h00; data = 8'h00;
    step();
    step();
    chk("ready_in_reset", {31'h0, ready}, 32'h0);
    chk("ctrl_outs_reset", {26'h0, rsttpu, txen, rxen, msk, flag, irq}, 32'h0);
    chk("slots_reset", {tx_slot, rx_slot}, 32'h0);
    chk("tmr_reset", {16'h0, tmr_val}, 32'h0);
    chk("rvalid_reset", {31'h0, rvalid}, 32'h0);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", {31'h0, ready}, 32'h1);
    for (int o = 0; o <= 8; o++) rd(8'(8'h20 + o), 8'h00, "reset_read");
    wr(8'h27, 8'hA5);
    rd(8'h27, 8'hA5, "tx1_readback");
    chk("tx_slot1_out", {16'h0, tx_slot}, 32'h0000A500);
    rd(8'h3F, 8'h00, "unmapped_read");
    wr(8'h26, 8'h5A);
    rd(8'h26, 8'h5A, "rx0_readback");
    chk("rx_slot0_out", {16'h0, rx_slot}, 32'h0000005A);
    wr(8'h23, 8'hFF);
    rd(8'h23, 8'h00, "cnt_hi_ro");
    wr(8'h3F, 8'h77);
    rd(8'h3F, 8'h00, "unmapped_write_ignored");
    we = 1'b1; re = 1'b1; addr = 8'h25; data = 8'h11;
    step();
    we = 1'b0; re = 1'b0;
    rd(8'h25, 8'h11, "tx0_after_we_re");
    wr(8'h20, 8'h06);
    chk("slot_enables", {30'h0, rxen, txen}, 32'h3);
    rd(8'h20, 8'h06, "ctrl_readback");
    wr(8'h21, 8'h00);
    wr(8'h22, 8'h04);
    chk("tmr_val_4", {16'h0, tmr_val}, 32'h4);
    wr(8'h20, 8'h28);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("flag_k%0d", k), {31'h0, flag}, (k == 6) ? 32'h1 : 32'h0);
      chk($sformatf("irq_k%0d", k), {31'h0, irq}, 32'h0);
    end
    wr(8'h20, 8'h38);
    chk("flag_w1c_clear", {31'h0, flag}, 32'h0);
    chk("irq_follows", {31'h0, irq}, 32'h1);
    step();
    chk("irq_drop", {31'h0, irq}, 32'h0);
    step();
    chk("flag_k9", {31'h0, flag}, 32'h0);
    step();
    chk("flag_k10_period", {31'h0, flag}, 32'h1);
    step(); step(); step();
    wr(8'h20, 8'h38);
    chk("flag_set_wins", {31'h0, flag}, 32'h1);
    rd(8'h24, 8'h04, "cnt_lo_after_reload");
    rd(8'h20, 8'h38, "ctrl_with_flag");
    wr(8'h20, 8'h29);
    step();
    chk("rsttpu_out", {31'h0, rsttpu}, 32'h1);
    chk("flag_rsttpu_clr", {31'h0, flag}, 32'h0);
    step();
    chk("irq_after_rsttpu", {31'h0, irq}, 32'h0);
    rd(8'h24, 8'h00, "cnt_lo_rsttpu");
    rd(8'h23, 8'h00, "cnt_hi_rsttpu");
    chk("flag_held_rsttpu", {31'h0, flag}, 32'h0);
    wr(8'h20, 8'h28);
    step();
    step();
    chk("flag_k24", {31'h0, flag}, 32'h0);
    rd(8'h24, 8'h04, "cnt_lo_resume");
    step();
    step();
    chk("flag_k27", {31'h0, flag}, 32'h0);
    step();
    chk("flag_k28_resume", {31'h0, flag}, 32'h1);
    wr(8'h20, 8'h10);
    step();
`ifdef TPU_SHADOW_EN
    wr(8'h21, 8'h12);
    chk("shadow_hold", {16'h0, tmr_val}, 32'h0004);
    rd(8'h21, 8'h12, "shadow_read");
`else
    wr(8'h21, 8'h12);
    chk("tmr_hi_direct", {16'h0, tmr_val}, 32'h1204);
    rd(8'h21, 8'h12, "tmr_hi_read");
`endif
    wr(8'h22, 8'h34);
    chk("tmr_1234", {16'h0, tmr_val}, 32'h1234);
    rd(8'h22, 8'h34, "tmr_lo_read");
    rst = 1'b1; re = 1'b1; addr = 8'h27;
    #1;
    chk("ready_mid_reset", {31'h0, ready}, 32'h0);
    step();
    rst = 1'b0; re = 1'b0;
    step();
    chk("tx_cleared", {16'h0, tx_slot}, 32'h0);
    rd(8'h27, 8'h00, "tx1_after_reset");
    step(); step(); step();
    chk("scoreboard_drained", exp_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
